// File: rtl/seg7_scan.sv
// seg7_scan: four-digit multiplexed seven-segment scan driver with double-buffered display data.
// Define SEG7_SCAN_BLANK_EN to blank leading-zero digits 3..1.
module seg7_scan #(
   parameter int DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] dispin,
   input  logic [3:0]  dp_in,
   input  logic        load,
   output logic [7:0]  led,
   output logic [3:0]  sele,
   output logic        frame_done
);
   localparam int CW = $clog2(DIV);
   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic [15:0]   pend_val, disp_val;
   logic [3:0]    pend_dp, disp_dp;
   logic          pend_vld, tick, boundary, blank;
   logic [3:0]    nib;
   logic [6:0]    seg;
   assign tick       = cnt == CW'(DIV - 1);
   assign boundary   = tick && idx == 2'd3;
   assign frame_done = boundary;
   assign nib        = disp_val[{idx, 2'b00} +: 4];
`ifdef SEG7_SCAN_BLANK_EN
   // a digit is blank when it and every more-significant nibble are zero
   assign blank = idx != 2'd0 && (disp_val >> {idx, 2'b00}) == 16'd0;
`else
   assign blank = 1'b0;
`endif
   always_comb begin
      seg = 7'h7F;
      case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         default: seg = 7'h0E;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         idx      <= '0;
         pend_val <= '0;
         pend_dp  <= '0;
         pend_vld <= 1'b0;
         disp_val <= '0;
         disp_dp  <= '0;
         led      <= 8'hFF;
         sele     <= 4'hF;
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;
         if (tick) idx <= idx + 1'b1;
         if (load) begin
            pend_val <= dispin;
            pend_dp  <= dp_in;
         end
         // a load coinciding with the frame boundary bypasses the pending buffer
         if (boundary && (load || pend_vld)) begin
            disp_val <= load ? dispin : pend_val;
            disp_dp  <= load ? dp_in : pend_dp;
         end
         pend_vld <= boundary ? 1'b0 : (pend_vld | load);
         sele     <= tick ? 4'hF : ~(4'b0001 << idx);
         led      <= tick ? 8'hFF : {~disp_dp[idx], blank ? 7'h7F : seg};
      end
   end
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: randomized and directed checks of seg7_scan against a cycle-count reference model.
module tb_seg7_scan;
   localparam int DIV = 4;
   localparam int FR  = 4 * DIV;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] dispin = '0;
   logic [3:0]  dp_in = '0;
   logic        load = 1'b0;
   logic [7:0]  led;
   logic [3:0]  sele;
   logic        frame_done;
   seg7_scan #(.DIV(DIV)) dut (
      .clk(clk), .rst(rst), .dispin(dispin), .dp_in(dp_in), .load(load),
      .led(led), .sele(sele), .frame_done(frame_done)
   );
   always #5 clk = ~clk;
   logic [7:0] lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
   int          c, n_cmp, n_bad;
   logic [15:0] m_disp, m_pval;
   logic [3:0]  m_dp, m_pdp;
   bit          m_pv;
   logic [7:0]  exp_led;
   logic [3:0]  exp_sele;
   logic        exp_fd;
   logic [7:0]  seen [4];
   function automatic logic [7:0] mdec(input logic [15:0] v, input logic [3:0] d, input int n);
      logic [3:0] nb = v[4*n +: 4];
      logic [7:0] r = lut[nb];
      if (d[n]) r[7] = 1'b0;
`ifdef SEG7_SCAN_BLANK_EN
      if (n > 0 && (32'(v) >> (4 * n)) == 0) r[6:0] = 7'h7F;
`endif
      return r;
   endfunction
   // c is the number of cycles elapsed since reset; slot, phase and frame follow by division
   task automatic step(input logic r, input logic ld, input logic [15:0] v, input logic [3:0] d);
      int dig;
      rst = r; load = ld; dispin = v; dp_in = d;
      @(posedge clk);
      if (r) begin
         exp_led = 8'hFF; exp_sele = 4'hF;
         c = 0; m_disp = '0; m_dp = '0; m_pv = 0; m_pval = '0; m_pdp = '0;
      end else begin
         dig = (c / DIV) % 4;
         exp_sele = (c % DIV == DIV - 1) ? 4'hF : ~(4'b0001 << dig);
         exp_led  = (c % DIV == DIV - 1) ? 8'hFF : mdec(m_disp, m_dp, dig);
         if (c % FR == FR - 1 && ld) begin
            m_disp = v; m_dp = d; m_pv = 0;
         end else if (c % FR == FR - 1 && m_pv) begin
            m_disp = m_pval; m_dp = m_pdp; m_pv = 0;
         end else if (ld) begin
            m_pval = v; m_pdp = d; m_pv = 1;
         end
         c++;
      end
      exp_fd = !r && (c % DIV == DIV - 1) && ((c / DIV) % 4 == 3);
      #1;
   endtask
   task automatic idle_to(input int ph);
      for (int k = 0; k < 64 && c % FR != ph; k++) step(0, 0, '0, '0);
   endtask
   task automatic record();
      for (int n = 0; n < 4; n++) if (sele == ~(4'b0001 << n)) seen[n] = led;
   endtask
   task automatic test_reset();
      logic [3:0] seq [16] = '{4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF,
                               4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF};
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 16'hFFFF, 4'hF);
         n_cmp++;
         if (led !== 8'hFF || sele !== 4'hF || frame_done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hold: led=%h sele=%h fd=%b want FF F 0", led, sele, frame_done);
         end
      end
      step(0, 0, '0, '0);
      n_cmp++;
      if (led !== 8'hC0 || sele !== 4'hE) begin
         n_bad++;
         $display("FAIL reset_first: led=%h sele=%h want C0 E", led, sele);
      end
      for (int i = 1; i < 33; i++) begin
         step(0, 0, '0, '0);
         n_cmp++;
         if (sele !== seq[i % 16] || frame_done !== (i % 16 == 14)) begin
            n_bad++;
            $display("FAIL scan_seq[%0d]: sele=%h fd=%b want %h %b", i, sele, frame_done, seq[i % 16], i % 16 == 14);
         end
      end
   endtask
   task automatic test_load_boundary();
      idle_to(6);
      seen = '{default: 8'h00};
      for (int i = 0; i < 26; i++) begin
         step(0, i == 0, 16'h12AF, 4'b0010);
         if (i >= 10) record();
         n_cmp++;
         if (led !== exp_led || sele !== exp_sele || frame_done !== exp_fd) begin
            n_bad++;
            $display("FAIL load_boundary[%0d]: %h %h %b want %h %h %b", i, led, sele, frame_done, exp_led, exp_sele, exp_fd);
         end
      end
      n_cmp++;
      if (seen[0] !== 8'h8E || seen[1] !== 8'h08 || seen[2] !== 8'hA4 || seen[3] !== 8'hF9) begin
         n_bad++;
         $display("FAIL load_digits: %h %h %h %h want 8E 08 A4 F9", seen[0], seen[1], seen[2], seen[3]);
      end
   endtask
   task automatic test_simultaneous();
      logic hit = 0;
      idle_to(5);
      seen = '{default: 8'h00};
      for (int i = 0; i < 44; i++) begin
         if (i == 0) step(0, 1, 16'h7777, 4'h0);
         else if (!hit && frame_done === 1'b1) begin
            hit = 1;
            step(0, 1, 16'h0005, 4'h0);
            step(0, 0, '0, '0);
            n_cmp++;
            if (led !== 8'h92 || sele !== 4'hE) begin
               n_bad++;
               $display("FAIL simul_first: led=%h sele=%h want 92 E", led, sele);
            end
         end else step(0, 0, '0, '0);
         if (i >= 27) record();
         n_cmp++;
         if (led !== exp_led || sele !== exp_sele || frame_done !== exp_fd) begin
            n_bad++;
            $display("FAIL simultaneous[%0d]: %h %h %b want %h %h %b", i, led, sele, frame_done, exp_led, exp_sele, exp_fd);
         end
      end
      n_cmp++;
      if (!hit || seen[0] !== 8'h92 || seen[1] !== 8'hC0) begin
         n_bad++;
         $display("FAIL simul_hold: hit=%b d0=%h d1=%h want 1 92 C0", hit, seen[0], seen[1]);
      end
   endtask
   task automatic test_back_to_back();
      logic [15:0] vals [3] = '{16'h1111, 16'h2222, 16'h3333};
      idle_to(1);
      seen = '{default: 8'h00};
      for (int i = 0; i < 31; i++) begin
         step(0, i % 3 == 0 && i < 9, vals[(i / 3) % 3], 4'h0);
         if (i >= 15) record();
         n_cmp++;
         if (led !== exp_led || sele !== exp_sele || frame_done !== exp_fd) begin
            n_bad++;
            $display("FAIL back_to_back[%0d]: %h %h %b want %h %h %b", i, led, sele, frame_done, exp_led, exp_sele, exp_fd);
         end
      end
      n_cmp++;
      if (seen[0] !== 8'hB0 || seen[1] !== 8'hB0 || seen[2] !== 8'hB0 || seen[3] !== 8'hB0) begin
         n_bad++;
         $display("FAIL b2b_digits: %h %h %h %h want B0 x4", seen[0], seen[1], seen[2], seen[3]);
      end
   endtask
   task automatic test_blanking();
`ifdef SEG7_SCAN_BLANK_EN
      logic [7:0] hi = 8'hFF;
`else
      logic [7:0] hi = 8'hC0;
`endif
      idle_to(1);
      seen = '{default: 8'h00};
      for (int i = 0; i < 31; i++) begin
         step(0, i == 0, 16'h0040, 4'h0);
         if (i >= 15) record();
         n_cmp++;
         if (led !== exp_led || sele !== exp_sele || frame_done !== exp_fd) begin
            n_bad++;
            $display("FAIL blanking[%0d]: %h %h %b want %h %h %b", i, led, sele, frame_done, exp_led, exp_sele, exp_fd);
         end
      end
      n_cmp++;
      if (seen[0] !== 8'hC0 || seen[1] !== 8'h99 || seen[2] !== hi || seen[3] !== hi) begin
         n_bad++;
         $display("FAIL blank_digits: %h %h %h %h want C0 99 %h %h", seen[0], seen[1], seen[2], seen[3], hi, hi);
      end
   endtask
   task automatic test_reset_mid_frame();
      int leaks = 0;
      idle_to(2);
      seen = '{default: 8'h00};
      for (int i = 0; i < 40; i++) begin
         step(i == 3 || i == 4, i == 0, 16'hFFFF, 4'h0);
         if (i >= 5) record();
         if (i >= 5 && led[6:0] === 7'h0E) leaks++;
         n_cmp++;
         if (led !== exp_led || sele !== exp_sele || frame_done !== exp_fd) begin
            n_bad++;
            $display("FAIL reset_mid[%0d]: %h %h %b want %h %h %b", i, led, sele, frame_done, exp_led, exp_sele, exp_fd);
         end
      end
      n_cmp++;
      if (leaks != 0 || seen[0] !== 8'hC0) begin
         n_bad++;
         $display("FAIL reset_discard: leaks=%0d d0=%h want 0 C0", leaks, seen[0]);
      end
   endtask
   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         step($urandom % 113 == 0, $urandom % 7 == 0, 16'($urandom), 4'($urandom));
         n_cmp++;
         if (led !== exp_led || sele !== exp_sele || frame_done !== exp_fd) begin
            n_bad++;
            $display("FAIL random[%0d]: %h %h %b want %h %h %b", i, led, sele, frame_done, exp_led, exp_sele, exp_fd);
         end
      end
   endtask
   initial begin
      test_reset();
      test_load_boundary();
      test_simultaneous();
      test_back_to_back();
      test_blanking();
      test_reset_mid_frame();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/seg7_scan.md
# seg7_scan

Four-digit multiplexed seven-segment scan driver that sits directly downstream of the CPU SOPC's display output and drives the board's `led`/`sele` pins. It captures a 16-bit hex value plus decimal points on a load strobe and double-buffers them, so a digit is never torn mid-frame. It cycles one digit at a time using a refresh prescaler and inserts one dead cycle between digits to suppress ghosting. Segment and select outputs are registered and active-low.

## Interface
- `DIV`, default 50000: clk cycles per digit slot; legal range ≥ 2; counter width is `$clog2(DIV)`.
- `clk` in, 1 bit: the only clock; all state updates on its rising edge.
- `rst` in, 1 bit: synchronous, active-high reset.
- `dispin` in, 16 bits: four hex nibbles; `[3:0]` is digit 0 (rightmost), `[15:12]` is digit 3.
- `dp_in` in, 4 bits: decimal point per digit; bit n belongs to digit n; 1 = lit.
- `load` in, 1 bit: one-cycle strobe that captures `dispin`/`dp_in`.
- `led` out, 8 bits: segments `{dp,g,f,e,d,c,b,a}`; active-low.
- `sele` out, 4 bits: digit select; bit n = digit n; one-hot active-low.
- `frame_done` out, 1 bit: one-cycle pulse at the end of digit 3's slot.

## Operation
- **Prescaler `cnt`:** counts 0..DIV-1, then wraps to 0. `tick` = (cnt == DIV-1).
- **Digit index `idx`:** 2 bits. Advances on `tick` through 0→1→2→3→0.
- **Pending buffer:** `pend_val[15:0]`, `pend_dp[3:0]`, `pend_vld`. When `load` = 1, capture the inputs and set `pend_vld`. A later `load` overwrites the buffer; the last one wins.
- **Display buffer:** `disp_val`, `disp_dp`. Updated only at the frame boundary, where the boundary is `tick && idx == 3`:
  - If `load` is also high in that cycle: `disp` takes `dispin`/`dp_in` directly, and `pend_vld` clears.
  - Else if `pend_vld` is set: `disp` takes the pending buffer, and `pend_vld` clears.
  - Else: `disp` holds.
- **Hex decode** of nibble n (bit 7 = dp = 1/off), active-low:
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8
  - 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E
  - If `disp_dp[n]` is set, bit 7 is 0.
- **Output register:**
  - When `tick` = 1: load the dead state, `sele` = 4'hF and `led` = 8'hFF.
  - Otherwise: `sele` = ~(4'b0001 << idx) and `led` = decode(disp_val nibble idx).
- `frame_done` = `tick && idx == 3`. It is combinational from registers.
- **Reset (while `rst` = 1 at an edge):**
  - `cnt` = 0, `idx` = 0.
  - `disp_val` = 0, `disp_dp` = 0, pending buffer cleared.
  - `led` = 8'hFF, `sele` = 4'hF.
  - `frame_done` = 0.
  - A reset mid-frame discards any pending load.
- `load` while `rst` = 1 is ignored.

## Timing
- Output latency is one cycle from `idx`/`disp` to `led`/`sele`.
- First edge with `rst` = 0: `sele` = 4'hE, `led` = 8'hC0 (digit 0 shows '0').
- Each slot lasts DIV cycles: DIV-1 lit cycles, then 1 dead cycle. The dead cycle is the cycle after `tick`.
- One frame is 4·DIV cycles.
- Loaded data appears on the pins no earlier than the first cycle of the next digit-0 slot after the next frame boundary. Worst case is 4·DIV+1 cycles after `load`.
- `frame_done` rises in the cycle where cnt = DIV-1 and idx = 3. It is high for exactly 1 cycle per frame.

## Configuration
- Macro: `SEG7_SCAN_BLANK_EN`.
- **Defined (leading-zero blanking):**
  - Digit n (n = 3..1) is blanked when its nibble and every more-significant nibble are zero. Blanked means segments a–g are off.
  - The decimal point is still driven from `disp_dp[n]`.
  - Digit 0 is never blanked.
  - `sele` scanning is unchanged.
- **Undefined:** all four digits always display their nibble. No blanking logic is compiled.

## Test plan
All scenarios use `DIV` = 4.
- **Reset:** hold `rst` 3 cycles, then release.
  - During reset: `led` = FF, `sele` = F.
  - First edge after release: `sele` = E, `led` = C0.
  - `sele` then follows E,E,E,F,D,D,D,F,B… with period 16.
- **Load and frame boundary:** pulse `load` with `dispin` = 16'h12AF, `dp_in` = 4'b0010 mid-frame.
  - The current frame keeps its old value.
  - The next frame shows digit0 8E, digit1 08 (A with dp), digit2 A4, digit3 F9.
- **Simultaneous load and boundary:** assert `load` (`dispin` = 16'h0005) in the cycle where `frame_done` = 1.
  - Digit 0 shows 92 in the very next lit slot.
  - `pend_vld` ends up clear.
- **Back-to-back loads:** three loads (16'h1111, 16'h2222, 16'h3333) within one frame → the next frame shows only 3333 (B0 on all digits).
- **Blanking:** `dispin` = 16'h0040.
  - Macro defined: digits 3 and 2 show FF, digit 1 shows 99, digit 0 shows C0.
  - Macro undefined: digits 3 and 2 show C0.
- **Reset mid-frame:** `load` 16'hFFFF, then `rst` before the boundary → after release, digit 0 shows C0 and the pending value never appears.
